// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with status flags,
// optional signed saturation and an internal accumulator.
//   S1 registers the operand beat, S2 computes and registers result and flags.
//   Outputs are driven from S2 registers only; in_ready is combinational.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD    = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 3'd1;
    localparam logic [OP_W-1:0] OP_AND    = 3'd2;
    localparam logic [OP_W-1:0] OP_OR     = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_SLT    = 3'd5;
    localparam logic [OP_W-1:0] OP_ACC    = 3'd6;
    localparam logic [OP_W-1:0] OP_CLRACC = 3'd7;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // S1 operand registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic [OP_W-1:0]  s1_op_q,    s1_op_d;
    logic             s1_sat_q,   s1_sat_d;

    // S2 result registers and accumulator
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q,     out_y_d;
    logic             out_zero_q,  out_zero_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q,   out_ovf_d;
    logic [WIDTH-1:0] acc_q,       acc_d;

    // Pipeline enables
    logic s2_en;
    logic s1_en;

    // Datapath intermediates
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH:0]   add_r;
    logic [WIDTH:0]   sub_r;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic [WIDTH-1:0] res_y;
    logic             res_carry;
    logic             res_ovf;

    // Stage advance: S2 frees when empty or drained, S1 frees when empty or moving on
    always_comb begin
        s2_en    = !out_valid_q | out_ready;
        s1_en    = !s1_valid_q | s2_en;
        in_ready = s1_en & rst_n;
    end

    // Shared adder/subtractor; ACC reuses the adder with the accumulator as first operand
    always_comb begin
        add_x   = (s1_op_q == OP_ACC) ? acc_q  : s1_a_q;
        add_y   = (s1_op_q == OP_ACC) ? s1_a_q : s1_b_q;
        add_r   = {1'b0, add_x} + {1'b0, add_y};
        sub_r   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_r[WIDTH-1] != add_x[WIDTH-1]);
        sub_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (sub_r[WIDTH-1] != s1_a_q[WIDTH-1]);
        slt_bit = $signed(s1_a_q) < $signed(s1_b_q);
    end

    // Result and flag selection; on overflow the true result has the sign of the first operand
    always_comb begin
        res_y     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_ACC: begin
                res_carry = add_r[WIDTH];
                res_ovf   = add_ovf;
                if (s1_sat_q && add_ovf) begin
                    res_y = add_x[WIDTH-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    res_y = add_r[WIDTH-1:0];
                end
            end
            OP_SUB: begin
                res_carry = sub_r[WIDTH];
                res_ovf   = sub_ovf;
                if (s1_sat_q && sub_ovf) begin
                    res_y = s1_a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    res_y = sub_r[WIDTH-1:0];
                end
            end
            OP_AND:    res_y = s1_a_q & s1_b_q;
            OP_OR:     res_y = s1_a_q | s1_b_q;
            OP_XOR:    res_y = s1_a_q ^ s1_b_q;
            OP_SLT:    res_y = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_CLRACC: res_y = '0;
            default:   res_y = '0;
        endcase
    end

    // S1 next state: capture a new beat whenever S1 can advance
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_sat_d   = s1_sat_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_op_d  = in_op;
                s1_sat_d = in_sat;
            end
        end
    end

    // S2 next state and accumulator: both move only when the S1 beat advances
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_zero_d  = out_zero_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        acc_d       = acc_q;
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_y_d     = res_y;
                out_zero_d  = (res_y == '0);
                out_carry_d = res_carry;
                out_ovf_d   = res_ovf;
                if (s1_op_q == OP_ACC) begin
                    acc_d = res_y;
                end else if (s1_op_q == OP_CLRACC) begin
                    acc_d = '0;
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_zero_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_zero_q  <= out_zero_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            acc_q       <= acc_d;
        end
    end

    // Outputs come straight from S2 registers
    always_comb begin
        out_valid = out_valid_q;
        out_y     = out_y_q;
        out_zero  = out_zero_q;
        out_carry = out_carry_q;
        out_ovf   = out_ovf_q;
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

    localparam int unsigned WIDTH = 8;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_OR     = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_SLT    = 3'd5;
    localparam logic [2:0] OP_ACC    = 3'd6;
    localparam logic [2:0] OP_CLRACC = 3'd7;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one beat into an empty pipeline and check its result
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic sat, input logic [7:0] ey,
                         input logic ez, input logic ec, input logic eo);
        int waited;
        out_ready = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_sat    = sat;
        in_valid  = 1'b1;
        #1;
        chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        waited   = 0;
        while (!out_valid && waited < 8) begin
            step();
            waited++;
        end
        chk({tag, ".vld"},   64'(out_valid), 64'd1);
        chk({tag, ".y"},     64'(out_y),     64'(ey));
        chk({tag, ".zero"},  64'(out_zero),  64'(ez));
        chk({tag, ".carry"}, 64'(out_carry), 64'(ec));
        chk({tag, ".ovf"},   64'(out_ovf),   64'(eo));
        step();
    endtask

    logic [2:0] s_op [5];
    logic [7:0] s_a  [5];
    logic [7:0] s_y  [5];
    logic       s_z  [5];
    logic [7:0] got  [8];
    int         n_got;
    int         n_acc;
    logic [7:0] next_a;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_sat    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        step();
        step();
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_y",     64'(out_y),     64'd0);
        chk("rst.out_zero",  64'(out_zero),  64'd0);
        chk("rst.out_carry", 64'(out_carry), 64'd0);
        chk("rst.out_ovf",   64'(out_ovf),   64'd0);
        rst_n = 1'b1;
        step();

        // Arithmetic, saturation, flags
        do_op("add_ovf",   OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
        do_op("add_sat",   OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);
        do_op("add_carry", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        do_op("sub_borrow",OP_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
        do_op("sub_sat",   OP_SUB, 8'h80, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
        do_op("sub_zero",  OP_SUB, 8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("slt_t",     OP_SLT, 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("slt_f",     OP_SLT, 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("and",       OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        do_op("or",        OP_OR,  8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0);
        do_op("xor",       OP_XOR, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0);

        // Streaming accumulator, out_ready held high
        s_op[0] = OP_ACC;    s_a[0] = 8'h10; s_y[0] = 8'h10; s_z[0] = 1'b0;
        s_op[1] = OP_ACC;    s_a[1] = 8'h20; s_y[1] = 8'h30; s_z[1] = 1'b0;
        s_op[2] = OP_ACC;    s_a[2] = 8'h30; s_y[2] = 8'h60; s_z[2] = 1'b0;
        s_op[3] = OP_CLRACC; s_a[3] = 8'h00; s_y[3] = 8'h00; s_z[3] = 1'b1;
        s_op[4] = OP_ACC;    s_a[4] = 8'h05; s_y[4] = 8'h05; s_z[4] = 1'b0;
        out_ready = 1'b1;
        in_sat    = 1'b0;
        in_b      = 8'hAA;
        for (int s = 1; s <= 7; s++) begin
            if (s <= 5) begin
                in_valid = 1'b1;
                in_op    = s_op[s-1];
                in_a     = s_a[s-1];
                #1;
                chk($sformatf("stream.rdy%0d", s), 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (s == 1) begin
                chk("stream.latency", 64'(out_valid), 64'd0);
            end else if (s <= 6) begin
                chk($sformatf("stream.vld%0d", s-2), 64'(out_valid), 64'd1);
                chk($sformatf("stream.y%0d", s-2),   64'(out_y),     64'(s_y[s-2]));
                chk($sformatf("stream.z%0d", s-2),   64'(out_zero),  64'(s_z[s-2]));
            end else begin
                chk("stream.drained", 64'(out_valid), 64'd0);
            end
        end

        // Backpressure: stall the consumer while the source keeps offering beats
        out_ready = 1'b0;
        in_op     = OP_ADD;
        in_b      = 8'h00;
        in_sat    = 1'b0;
        in_valid  = 1'b1;
        n_acc     = 0;
        next_a    = 8'h01;
        for (int c = 0; c < 6; c++) begin
            in_a = next_a;
            #1;
            if (in_ready) begin
                n_acc++;
                next_a = next_a + 8'h01;
            end
            step();
        end
        chk("bp.accepted",  64'(n_acc),     64'd2);
        chk("bp.in_ready",  64'(in_ready),  64'd0);
        chk("bp.out_valid", 64'(out_valid), 64'd1);
        chk("bp.out_y",     64'(out_y),     64'h01);
        step();
        chk("bp.y_hold",    64'(out_y),     64'h01);

        // Release with a simultaneous new beat while both stages are full
        in_a      = next_a;
        out_ready = 1'b1;
        #1;
        chk("bp.full_accept", 64'(in_ready), 64'd1);
        n_got = 0;
        if (out_valid) begin
            got[n_got] = out_y;
            n_got++;
        end
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid && n_got < 8) begin
                got[n_got] = out_y;
                n_got++;
            end
            step();
        end
        chk("bp.count", 64'(n_got), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp.order%0d", i), 64'(got[i]), 64'(i + 1));
        end

        // Reset mid-stream with beats in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op = OP_CLRACC; in_a = 8'h00; step();
        in_op = OP_ACC;    in_a = 8'h50; step();
        in_op = OP_ACC;    in_a = 8'h05; step();
        in_op = OP_ACC;    in_a = 8'h01; step();
        chk("mid.acc55_vld", 64'(out_valid), 64'd1);
        chk("mid.acc55_y",   64'(out_y),     64'h55);
        in_a  = 8'h02;
        rst_n = 1'b0;
        #1;
        chk("mid.rst_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        chk("mid.out_valid", 64'(out_valid), 64'd0);
        chk("mid.out_y",     64'(out_y),     64'd0);
        chk("mid.out_zero",  64'(out_zero),  64'd0);
        chk("mid.out_carry", 64'(out_carry), 64'd0);
        chk("mid.out_ovf",   64'(out_ovf),   64'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("mid.no_ghost", 64'(out_valid), 64'd0);
        do_op("mid.acc01", OP_ACC, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Bound the run in case the pipeline stalls forever
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
